mem_arbiter: RTL and testbench

- Sits between the RV32I core and one single-port synchronous SRAM.
- Accepts instruction-fetch and data load/store requests from the core over valid/ready handshakes.
- Arbitrates the two requests onto the SRAM port and returns registered responses; the core stalls while `busy` is high.
- Replaces the combinational dual-port memory model so the core can run on real block RAM.

---
 rtl/mem_arbiter_pkg.sv | 25 ++
 rtl/mem_arbiter_if.sv | 40 ++++
 rtl/mem_arbiter_sram.sv | 39 +++
 rtl/mem_arbiter.sv | 147 ++++++++++++++
 tb/tb_mem_arbiter.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the instruction/data arbiter in front of a single-port SRAM.
// Holds the FSM encoding, grant encoding, bus widths and the alignment helper.
package mem_arb_pkg;

   localparam int WORD_LEN   = 32;
   localparam int MEM_ADDR_W = 14;

   localparam logic [WORD_LEN-1:0] NOP_INST = 32'h0000_0013;

   localparam logic GRANT_I = 1'b0;
   localparam logic GRANT_D = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_I_RD = 3'd1,
      ST_D_RD = 3'd2,
      ST_D_WR = 3'd3,
      ST_DONE = 3'd4
   } arb_state_e;

   function automatic logic is_misaligned(input logic [1:0] byte_lsb);
      return (byte_lsb != 2'b00);
   endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Core-side fetch/data handshakes plus the SRAM port, bundled for the arbiter.
// The core drives through master, the arbiter sits on slave, the SRAM on mem.
interface mem_arbiter_if;
   import mem_arb_pkg::*;

   logic                  i_valid;
   logic [WORD_LEN-1:0]   i_addr;
   logic                  i_ready;
   logic [WORD_LEN-1:0]   i_inst;
   logic                  d_valid;
   logic                  d_wen;
   logic [WORD_LEN-1:0]   d_addr;
   logic [WORD_LEN-1:0]   d_wdata;
   logic                  d_ready;
   logic [WORD_LEN-1:0]   d_rdata;
   logic                  d_err;
   logic                  busy;
   logic                  mem_en;
   logic                  mem_wen;
   logic [MEM_ADDR_W-1:0] mem_addr;
   logic [WORD_LEN-1:0]   mem_wdata;
   logic [WORD_LEN-1:0]   mem_rdata;

   modport master (
      output i_valid, i_addr, d_valid, d_wen, d_addr, d_wdata,
      input  i_ready, i_inst, d_ready, d_rdata, d_err, busy
   );

   modport slave (
      input  i_valid, i_addr, d_valid, d_wen, d_addr, d_wdata, mem_rdata,
      output i_ready, i_inst, d_ready, d_rdata, d_err, busy,
      output mem_en, mem_wen, mem_addr, mem_wdata
   );

   modport mem (
      input  mem_en, mem_wen, mem_addr, mem_wdata,
      output mem_rdata
   );

endinterface

// File: rtl/mem_arbiter_sram.sv
// Behavioural single-port synchronous SRAM: one-cycle read latency, write-first.
// Stands in for block RAM in simulation and on the FPGA top.
module sync_sram
   import mem_arb_pkg::*;
#(
   parameter int AW = MEM_ADDR_W,
   parameter int DW = WORD_LEN
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          en_i,
   input  logic          wen_i,
   input  logic [AW-1:0] addr_i,
   input  logic [DW-1:0] wdata_i,
   output logic [DW-1:0] rdata_o
);

   logic [DW-1:0] mem_q [0:(1<<AW)-1];
   logic [DW-1:0] rdata_q;

   // Storage array write port.
   always_ff @(posedge clk) begin
      if (en_i && wen_i) begin
         mem_q[addr_i] <= wdata_i;
      end
   end

   // Read register; a write returns the new data on the same port.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata_q <= '0;
      end else if (en_i) begin
         rdata_q <= wen_i ? wdata_i : mem_q[addr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates RV32I instruction fetches and data loads/stores onto one SRAM port.
// Responses are registered; the core stalls on busy.
module mem_arbiter
   import mem_arb_pkg::*;
(
   input  logic          clk,
   input  logic          rst_n,
   mem_arbiter_if.slave  bus
);

   arb_state_e            state_q, state_d;
   logic                  last_grant_q, last_grant_d;
   logic [WORD_LEN-1:0]   i_inst_q, i_inst_d;
   logic [WORD_LEN-1:0]   d_rdata_q, d_rdata_d;
   logic                  i_ready_q, i_ready_d;
   logic                  d_ready_q, d_ready_d;
   logic                  d_err_q, d_err_d;
   logic                  busy_q, busy_d;

   logic                  accept_s;
   logic                  grant_s;
   logic                  d_misal_s;
   logic                  mem_en_s;
   logic                  mem_wen_s;
   logic [MEM_ADDR_W-1:0] mem_addr_s;
   logic [WORD_LEN-1:0]   mem_wdata_s;

   // Next-state, arbitration and SRAM request decode.
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      i_inst_d     = i_inst_q;
      d_rdata_d    = d_rdata_q;
      i_ready_d    = 1'b0;
      d_ready_d    = 1'b0;
      d_err_d      = 1'b0;
      accept_s     = 1'b0;
      grant_s      = GRANT_I;
      mem_en_s     = 1'b0;
      mem_wen_s    = 1'b0;
      mem_addr_s   = '0;
      mem_wdata_s  = '0;
      d_misal_s    = is_misaligned(bus.d_addr[1:0]);

      case (state_q)
         ST_IDLE: begin
            // Both requesting: serve whichever side was not served last.
            if (bus.i_valid && bus.d_valid) begin
               accept_s = 1'b1;
               grant_s  = (last_grant_q == GRANT_I) ? GRANT_D : GRANT_I;
            end else if (bus.d_valid) begin
               accept_s = 1'b1;
               grant_s  = GRANT_D;
            end else if (bus.i_valid) begin
               accept_s = 1'b1;
               grant_s  = GRANT_I;
            end else begin
               accept_s = 1'b0;
            end

            if (accept_s) begin
               last_grant_d = grant_s;
               if (grant_s == GRANT_I) begin
                  mem_en_s   = 1'b1;
                  mem_addr_s = bus.i_addr[MEM_ADDR_W+1:2];
                  state_d    = ST_I_RD;
               end else if (d_misal_s) begin
                  d_ready_d = 1'b1;
                  d_err_d   = 1'b1;
                  state_d   = ST_DONE;
               end else begin
                  mem_en_s   = 1'b1;
                  mem_wen_s  = bus.d_wen;
                  mem_addr_s = bus.d_addr[MEM_ADDR_W+1:2];
                  if (bus.d_wen) begin
                     mem_wdata_s = bus.d_wdata;
                     state_d     = ST_D_WR;
                  end else begin
                     state_d     = ST_D_RD;
                  end
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_I_RD: begin
            i_inst_d  = bus.mem_rdata;
            i_ready_d = 1'b1;
            state_d   = ST_DONE;
         end
         ST_D_RD: begin
            d_rdata_d = bus.mem_rdata;
            d_ready_d = 1'b1;
            state_d   = ST_DONE;
         end
         ST_D_WR: begin
            d_ready_d = 1'b1;
            state_d   = ST_DONE;
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   // State, grant history and registered responses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         last_grant_q <= GRANT_I;
         i_inst_q     <= NOP_INST;
         d_rdata_q    <= '0;
         i_ready_q    <= 1'b0;
         d_ready_q    <= 1'b0;
         d_err_q      <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         i_inst_q     <= i_inst_d;
         d_rdata_q    <= d_rdata_d;
         i_ready_q    <= i_ready_d;
         d_ready_q    <= d_ready_d;
         d_err_q      <= d_err_d;
         busy_q       <= busy_d;
      end
   end

   // The SRAM request is combinational from IDLE, so hold it off during reset.
   assign bus.mem_en    = rst_n & mem_en_s;
   assign bus.mem_wen   = rst_n & mem_wen_s;
   assign bus.mem_addr  = rst_n ? mem_addr_s  : '0;
   assign bus.mem_wdata = rst_n ? mem_wdata_s : '0;

   assign bus.i_ready = i_ready_q;
   assign bus.i_inst  = i_inst_q;
   assign bus.d_ready = d_ready_q;
   assign bus.d_rdata = d_rdata_q;
   assign bus.d_err   = d_err_q;
   assign bus.busy    = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter with a behavioural SRAM: directed scenarios, then random
// traffic checked cycle by cycle against a transaction-level model.
module tb_mem_arbiter;
   import mem_arb_pkg::*;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mem_arbiter_if bus();

   mem_arbiter u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   sync_sram u_sram (
      .clk     (clk),
      .rst_n   (rst_n),
      .en_i    (bus.mem_en),
      .wen_i   (bus.mem_wen),
      .addr_i  (bus.mem_addr),
      .wdata_i (bus.mem_wdata),
      .rdata_o (bus.mem_rdata)
   );

   int total_cnt = 0;
   int bad_cnt   = 0;

   logic [31:0] model_mem [0:31];

   task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act !== exp) begin
         bad_cnt++;
         $display("FAIL %s: got %h want %h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   task automatic next_cyc();
      @(posedge clk);
      #1;
   endtask

   // Starts in an IDLE cycle just after the clock edge; ends after the first idle cycle.
   task automatic data_xfer(input logic wen, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] exp_rd);
      logic mis;
      mis = (addr[1:0] != 2'b00);
      bus.d_valid = 1'b1;
      bus.d_wen   = wen;
      bus.d_addr  = addr;
      bus.d_wdata = wdata;
      @(negedge clk);
      chk_eq("d_T_busy", 32'(bus.busy), 32'd0);
      chk_eq("d_T_en", 32'(bus.mem_en), 32'(!mis));
      if (!mis) begin
         chk_eq("d_T_wen", 32'(bus.mem_wen), 32'(wen));
         chk_eq("d_T_addr", 32'(bus.mem_addr), 32'(addr[15:2]));
         if (wen) chk_eq("d_T_wdata", bus.mem_wdata, wdata);
      end
      next_cyc();
      @(negedge clk);
      chk_eq("d_T1_busy", 32'(bus.busy), 32'd1);
      chk_eq("d_T1_en", 32'(bus.mem_en), 32'd0);
      chk_eq("d_T1_ready", 32'(bus.d_ready), 32'(mis));
      chk_eq("d_T1_err", 32'(bus.d_err), 32'(mis));
      if (mis) begin
         chk_eq("d_mis_rdata", bus.d_rdata, exp_rd);
      end else begin
         next_cyc();
         @(negedge clk);
         chk_eq("d_T2_ready", 32'(bus.d_ready), 32'd1);
         chk_eq("d_T2_err", 32'(bus.d_err), 32'd0);
         chk_eq("d_T2_busy", 32'(bus.busy), 32'd1);
         chk_eq("d_T2_rdata", bus.d_rdata, exp_rd);
      end
      next_cyc();
      bus.d_valid = 1'b0;
      @(negedge clk);
      chk_eq("d_end_busy", 32'(bus.busy), 32'd0);
      chk_eq("d_end_ready", 32'(bus.d_ready), 32'd0);
   endtask

   task automatic fetch_xfer(input logic [31:0] addr, input logic [31:0] exp_inst);
      bus.i_valid = 1'b1;
      bus.i_addr  = addr;
      @(negedge clk);
      chk_eq("i_T_en", 32'(bus.mem_en), 32'd1);
      chk_eq("i_T_wen", 32'(bus.mem_wen), 32'd0);
      chk_eq("i_T_addr", 32'(bus.mem_addr), 32'(addr[15:2]));
      next_cyc();
      @(negedge clk);
      chk_eq("i_T1_ready", 32'(bus.i_ready), 32'd0);
      chk_eq("i_T1_busy", 32'(bus.busy), 32'd1);
      next_cyc();
      @(negedge clk);
      chk_eq("i_T2_ready", 32'(bus.i_ready), 32'd1);
      chk_eq("i_T2_inst", bus.i_inst, exp_inst);
      next_cyc();
      bus.i_valid = 1'b0;
      @(negedge clk);
      chk_eq("i_T3_busy", 32'(bus.busy), 32'd0);
      chk_eq("i_T3_ready", 32'(bus.i_ready), 32'd0);
   endtask

   // Random-phase model state.
   int          next_free, acc_cyc, rdy_cyc;
   logic        last_g, rdy_d, rdy_err, pend_load, g, drop_i, drop_d;
   logic        exp_en, exp_wen, exp_ir, exp_dr, exp_err, exp_busy;
   logic [31:0] exp_addr, exp_wd, exp_inst, exp_rd, pend;

   initial begin
      bus.i_valid = 1'b0; bus.i_addr  = '0;
      bus.d_valid = 1'b0; bus.d_wen   = 1'b0;
      bus.d_addr  = '0;   bus.d_wdata = '0;

      // Reset with a store pending: SRAM port must stay quiet.
      bus.d_valid = 1'b1; bus.d_wen = 1'b1; bus.d_addr = 32'h0000_0010;
      repeat (3) @(negedge clk);
      chk_eq("rst_mem_en", 32'(bus.mem_en), 32'd0);
      chk_eq("rst_mem_wen", 32'(bus.mem_wen), 32'd0);
      bus.d_valid = 1'b0; bus.d_wen = 1'b0;
      rst_n = 1'b1;
      next_cyc();
      @(negedge clk);
      chk_eq("rst_i_ready", 32'(bus.i_ready), 32'd0);
      chk_eq("rst_d_ready", 32'(bus.d_ready), 32'd0);
      chk_eq("rst_d_err", 32'(bus.d_err), 32'd0);
      chk_eq("rst_i_inst", bus.i_inst, 32'h0000_0013);
      chk_eq("rst_d_rdata", bus.d_rdata, 32'd0);
      chk_eq("rst_busy", 32'(bus.busy), 32'd0);
      chk_eq("rst_idle_en", 32'(bus.mem_en), 32'd0);

      // Directed: fetch, store/load, misaligned load.
      next_cyc(); data_xfer(1'b1, 32'h8, 32'h00A0_0093, 32'd0);
      next_cyc(); fetch_xfer(32'h8, 32'h00A0_0093);
      next_cyc(); data_xfer(1'b1, 32'h40, 32'hDEAD_BEEF, 32'd0);
      next_cyc(); data_xfer(1'b0, 32'h40, 32'd0, 32'hDEAD_BEEF);
      next_cyc(); data_xfer(1'b0, 32'h42, 32'd0, 32'hDEAD_BEEF);

      // Both requesters held from reset: data, instr, data at cycles 0, 3, 6.
      next_cyc();
      rst_n = 1'b0;
      bus.i_valid = 1'b1; bus.i_addr = 32'h8;
      bus.d_valid = 1'b1; bus.d_wen  = 1'b0; bus.d_addr = 32'h40;
      @(negedge clk);
      chk_eq("arb_rst_en", 32'(bus.mem_en), 32'd0);
      next_cyc();
      rst_n = 1'b1;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         chk_eq($sformatf("arb_en_c%0d", c), 32'(bus.mem_en), 32'((c % 3) == 0));
         if ((c % 3) == 0)
            chk_eq($sformatf("arb_addr_c%0d", c), 32'(bus.mem_addr), (c == 3) ? 32'd2 : 32'd16);
         chk_eq($sformatf("arb_dr_c%0d", c), 32'(bus.d_ready), 32'(c == 2));
         chk_eq($sformatf("arb_ir_c%0d", c), 32'(bus.i_ready), 32'(c == 5));
         next_cyc();
      end
      bus.i_valid = 1'b0; bus.d_valid = 1'b0;
      @(negedge clk);
      chk_eq("arb_c8_dready", 32'(bus.d_ready), 32'd1);
      chk_eq("arb_c8_rdata", bus.d_rdata, 32'hDEAD_BEEF);
      repeat (2) next_cyc();

      // Reset in the middle of a fetch.
      bus.i_valid = 1'b1; bus.i_addr = 32'h8;
      @(negedge clk);
      chk_eq("mid_T_en", 32'(bus.mem_en), 32'd1);
      next_cyc();
      rst_n = 1'b0;
      bus.i_valid = 1'b0;
      @(negedge clk);
      chk_eq("mid_busy", 32'(bus.busy), 32'd0);
      chk_eq("mid_i_inst", bus.i_inst, NOP_INST);
      chk_eq("mid_i_ready", 32'(bus.i_ready), 32'd0);
      next_cyc();
      @(negedge clk);
      chk_eq("mid_T2_i_ready", 32'(bus.i_ready), 32'd0);
      rst_n = 1'b1;
      next_cyc();
      @(negedge clk);
      chk_eq("mid_post_busy", 32'(bus.busy), 32'd0);
      chk_eq("mid_post_i_ready", 32'(bus.i_ready), 32'd0);
      chk_eq("mid_post_i_inst", bus.i_inst, NOP_INST);
      next_cyc(); fetch_xfer(32'h8, 32'h00A0_0093);

      // Preload words 0..31, then reset so the model starts from known response state.
      for (int w = 0; w < 32; w++) begin
         model_mem[w] = $urandom;
         next_cyc();
         data_xfer(1'b1, 32'(w * 4), model_mem[w], 32'd0);
      end
      next_cyc();
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;

      // Random traffic against the model.
      next_free = 0; acc_cyc = -10; rdy_cyc = -10;
      last_g = GRANT_I; rdy_d = 1'b0; rdy_err = 1'b0; pend_load = 1'b0; pend = '0;
      drop_i = 1'b0; drop_d = 1'b0;
      exp_inst = NOP_INST; exp_rd = 32'd0;
      for (int cyc = 0; cyc < 900; cyc++) begin
         next_cyc();
         if (drop_i) begin
            bus.i_valid = 1'b0; drop_i = 1'b0;
         end else if (!bus.i_valid && $urandom_range(0, 2) == 0) begin
            bus.i_valid = 1'b1;
            bus.i_addr  = 32'($urandom_range(0, 31) * 4 + $urandom_range(0, 3));
         end
         if (drop_d) begin
            bus.d_valid = 1'b0; drop_d = 1'b0;
         end else if (!bus.d_valid && $urandom_range(0, 2) == 0) begin
            bus.d_valid = 1'b1;
            bus.d_wen   = 1'($urandom_range(0, 1));
            bus.d_wdata = $urandom;
            bus.d_addr  = 32'($urandom_range(0, 31) * 4);
            if ($urandom_range(0, 4) == 0) bus.d_addr = bus.d_addr + 32'($urandom_range(1, 3));
         end

         exp_en = 1'b0; exp_wen = 1'b0; exp_addr = '0; exp_wd = '0;
         if (cyc >= next_free && (bus.i_valid || bus.d_valid)) begin
            g = (bus.i_valid && bus.d_valid) ? ~last_g : bus.d_valid;
            last_g  = g;
            acc_cyc = cyc;
            rdy_d   = g;
            rdy_err = 1'b0;
            rdy_cyc = cyc + 2;
            next_free = cyc + 3;
            pend_load = 1'b0;
            if (!g) begin
               exp_en   = 1'b1;
               exp_addr = bus.i_addr / 4;
               pend     = model_mem[bus.i_addr / 4];
            end else if (bus.d_addr % 4 != 0) begin
               rdy_err   = 1'b1;
               rdy_cyc   = cyc + 1;
               next_free = cyc + 2;
            end else begin
               exp_en   = 1'b1;
               exp_wen  = bus.d_wen;
               exp_addr = bus.d_addr / 4;
               if (bus.d_wen) begin
                  exp_wd = bus.d_wdata;
                  model_mem[bus.d_addr / 4] = bus.d_wdata;
               end else begin
                  pend      = model_mem[bus.d_addr / 4];
                  pend_load = 1'b1;
               end
            end
         end
         exp_ir  = (cyc == rdy_cyc) && !rdy_d;
         exp_dr  = (cyc == rdy_cyc) && rdy_d;
         exp_err = exp_dr && rdy_err;
         if (exp_ir) exp_inst = pend;
         if (exp_dr && pend_load) exp_rd = pend;
         exp_busy = (cyc > acc_cyc) && (cyc < next_free);

         @(negedge clk);
         chk_eq("r_i_ready", 32'(bus.i_ready), 32'(exp_ir));
         chk_eq("r_d_ready", 32'(bus.d_ready), 32'(exp_dr));
         chk_eq("r_d_err", 32'(bus.d_err), 32'(exp_err));
         chk_eq("r_i_inst", bus.i_inst, exp_inst);
         chk_eq("r_d_rdata", bus.d_rdata, exp_rd);
         chk_eq("r_busy", 32'(bus.busy), 32'(exp_busy));
         chk_eq("r_mem_en", 32'(bus.mem_en), 32'(exp_en));
         chk_eq("r_mem_wen", 32'(bus.mem_wen), 32'(exp_wen));
         if (exp_en) chk_eq("r_mem_addr", 32'(bus.mem_addr), exp_addr);
         if (exp_wen) chk_eq("r_mem_wdata", bus.mem_wdata, exp_wd);
         if (exp_ir) drop_i = 1'b1;
         if (exp_dr) drop_d = 1'b1;
      end

      $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
      $finish;
   end

endmodule
